// File: rtl/cpu_cu.sv
// rtl/cpu_cu.sv - CPU control unit: fetch/decode/execute FSM driving the execution unit (optional CU_PERF_CNT_EN retired-instruction counter)
module cpu_cu #(
  parameter logic [3:0] ALU_PASS_R = 4'h0,
  parameter logic [3:0] ALU_PASS_S = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        c,
  input  logic        n,
  input  logic        z,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        ir_ld,
  output logic        adr_sel,
  output logic        s_sel,
  output logic        reg_w_en,
  output logic        mem_w_en,
  output logic [3:0]  alu_op,
  output logic [2:0]  w_adr,
  output logic [2:0]  r_adr,
  output logic [2:0]  s_adr,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_cnt
);

  localparam logic [2:0] ST_RST     = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [2:0] CL_ALU  = 3'b000;
  localparam logic [2:0] CL_LD   = 3'b001;
  localparam logic [2:0] CL_ST   = 3'b010;
  localparam logic [2:0] CL_JMP  = 3'b011;
  localparam logic [2:0] CL_BR   = 3'b100;
  localparam logic [2:0] CL_HALT = 3'b110;
  localparam logic [2:0] CL_ILL  = 3'b111;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       illegal_q;
  logic       cond_true;
  logic [2:0] iclass;

  assign iclass = ir[15:13];
  assign w_adr  = ir[8:6];
  assign r_adr  = ir[5:3];
  assign s_adr  = ir[2:0];
  assign halted  = (state == ST_HALT);
  assign illegal = illegal_q;

  // Branch condition select from the live IDP flags
  always_comb begin
    cond_true = 1'b0;
    case (ir[10:9])
      2'b00:   cond_true = z;
      2'b01:   cond_true = ~z;
      2'b10:   cond_true = c;
      default: cond_true = n;
    endcase
  end

  // Next-state decision; HALT and illegal classes leave from DECODE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:     state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = ST_DECODE;
      ST_DECODE:  state_nxt = (iclass == CL_HALT || iclass == CL_ILL) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: state_nxt = ST_FETCH;
      ST_HALT:    state_nxt = ST_HALT;
      default:    state_nxt = ST_RST;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RST;
    else       state <= state_nxt;
  end

  // Sticky illegal flag, set when DECODE sees the illegal class
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          illegal_q <= 1'b0;
    else if (state == ST_DECODE && iclass == CL_ILL)    illegal_q <= 1'b1;
  end

  // Moore strobes from state plus held IR
  always_comb begin
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    ir_ld    = 1'b0;
    adr_sel  = 1'b0;
    s_sel    = 1'b0;
    reg_w_en = 1'b0;
    mem_w_en = 1'b0;
    alu_op   = 4'h0;
    case (state)
      ST_FETCH: begin
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      ST_EXECUTE: begin
        case (iclass)
          CL_ALU: begin
            alu_op   = ir[12:9];
            reg_w_en = 1'b1;
          end
          CL_LD: begin
            adr_sel  = 1'b1;
            s_sel    = 1'b1;
            alu_op   = ALU_PASS_S;
            reg_w_en = 1'b1;
          end
          CL_ST: begin
            adr_sel  = 1'b1;
            alu_op   = ALU_PASS_S;
            mem_w_en = 1'b1;
          end
          CL_JMP: begin
            alu_op = ALU_PASS_R;
            pc_ld  = 1'b1;
          end
          CL_BR: begin
            alu_op = ALU_PASS_R;
            pc_ld  = cond_true;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef CU_PERF_CNT_EN
  logic [15:0] cnt_q;

  // Retired-instruction counter, bumps on the edge leaving EXECUTE
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt_q <= 16'h0000;
    else if (state == ST_EXECUTE) cnt_q <= cnt_q + 16'h0001;
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_cu.sv
// tb/tb_cpu_cu.sv - directed self-checking bench for cpu_cu
module tb_cpu_cu;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        c, n, z;
  logic        pc_ld, pc_inc, ir_ld, adr_sel, s_sel, reg_w_en, mem_w_en;
  logic [3:0]  alu_op;
  logic [2:0]  w_adr, r_adr, s_adr;
  logic        halted, illegal;
  logic [15:0] instr_cnt;

  int n_checks;
  int n_fail;
  int exp_cnt;

  // strobe order: pc_ld pc_inc ir_ld adr_sel s_sel reg_w_en mem_w_en
  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_FETCH = 7'b0110000;
  localparam logic [6:0] V_ALU   = 7'b0000010;
  localparam logic [6:0] V_LD    = 7'b0001110;
  localparam logic [6:0] V_ST    = 7'b0001001;
  localparam logic [6:0] V_PCLD  = 7'b1000000;

  cpu_cu dut (
    .clk(clk), .reset(reset), .ir(ir), .c(c), .n(n), .z(z),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld), .adr_sel(adr_sel),
    .s_sel(s_sel), .reg_w_en(reg_w_en), .mem_w_en(mem_w_en), .alu_op(alu_op),
    .w_adr(w_adr), .r_adr(r_adr), .s_adr(s_adr), .halted(halted),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {pc_ld, pc_inc, ir_ld, adr_sel, s_sel, reg_w_en, mem_w_en};
  endfunction

  function automatic logic [15:0] cnt_exp();
`ifdef CU_PERF_CNT_EN
    return exp_cnt[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full instruction: FETCH, DECODE, EXECUTE with checks in each cycle
  task automatic run_instr(input string tag, input logic [15:0] iv,
                           input logic [6:0] exp_ex, input logic [3:0] exp_alu,
                           input logic [8:0] exp_adr);
    ir = iv;
    step();
    check({tag, " fetch"}, strobes(), V_FETCH);
    check({tag, " cnt"}, instr_cnt, cnt_exp());
    step();
    check({tag, " decode"}, strobes(), V_IDLE);
    step();
    check({tag, " exec"}, strobes(), exp_ex);
    check({tag, " aluop"}, alu_op, exp_alu);
    check({tag, " adr"}, {w_adr, r_adr, s_adr}, exp_adr);
    check({tag, " status"}, {halted, illegal}, 2'b00);
    exp_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_cnt = 0;
    step();
    step();
    check("rst strobes", strobes(), V_IDLE);
    check("rst status", {halted, illegal}, 2'b00);
    check("rst aluop", alu_op, 4'h0);
    check("rst cnt", instr_cnt, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    ir = 16'h0000;
    c = 1'b0; n = 1'b0; z = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    do_reset();

    run_instr("alu0",  16'h0000, V_ALU, 4'h0, 9'h000);
    run_instr("ld",    16'h3628, V_LD,  4'h1, 9'h028);
    run_instr("alu5",  16'h0AD7, V_ALU, 4'h5, 9'h0D7);
    run_instr("st",    16'h401A, V_ST,  4'h1, 9'h01A);
    run_instr("jmp",   16'h6008, V_PCLD, 4'h0, 9'h008);
    z = 1'b1;
    run_instr("br z t",  16'h8008, V_PCLD, 4'h0, 9'h008);
    z = 1'b0;
    run_instr("br z nt", 16'h8008, V_IDLE, 4'h0, 9'h008);
    run_instr("br nz t", 16'h8208, V_PCLD, 4'h0, 9'h008);
    c = 1'b1;
    run_instr("br c t",  16'h8408, V_PCLD, 4'h0, 9'h008);
    c = 1'b0;
    run_instr("br c nt", 16'h8408, V_IDLE, 4'h0, 9'h008);
    n = 1'b1;
    run_instr("br n t",  16'h8608, V_PCLD, 4'h0, 9'h008);
    n = 1'b0;
    run_instr("br n nt", 16'h8608, V_IDLE, 4'h0, 9'h008);
    run_instr("nop",   16'hA000, V_IDLE, 4'h0, 9'h000);
    run_instr("nop2",  16'hA000, V_IDLE, 4'h0, 9'h000);

    // Reset in the middle of a store execute
    ir = 16'h401A;
    step();
    step();
    step();
    check("st pre-rst wen", mem_w_en, 1'b1);
    reset = 1'b1;
    #1;
    check("st async rst strobes", strobes(), V_IDLE);
    check("st async rst status", {halted, illegal}, 2'b00);
    @(negedge clk);
    do_reset();
    run_instr("after rst", 16'h0000, V_ALU, 4'h0, 9'h000);

    // HALT holds until reset, regardless of IR
    ir = 16'hC000;
    step();
    check("halt fetch", strobes(), V_FETCH);
    step();
    check("halt decode", strobes(), V_IDLE);
    for (int i = 0; i < 22; i++) begin
      step();
      ir = (i % 2 == 0) ? 16'h6008 : 16'h0000;
      check("halt hold strobes", strobes(), V_IDLE);
      check("halt hold status", {halted, illegal}, 2'b10);
    end
    check("halt cnt", instr_cnt, cnt_exp());
    reset = 1'b1;
    #1;
    check("halt async rst", {halted, illegal}, 2'b00);
    @(negedge clk);
    do_reset();

    // Illegal opcode
    ir = 16'hE000;
    step();
    step();
    step();
    check("ill status", {halted, illegal}, 2'b11);
    check("ill strobes", strobes(), V_IDLE);
    step();
    check("ill hold", {halted, illegal, strobes()}, {2'b11, V_IDLE});
    reset = 1'b1;
    #1;
    check("ill async rst", {halted, illegal}, 2'b00);
    @(negedge clk);
    do_reset();
    run_instr("post ill", 16'h3628, V_LD, 4'h1, 9'h028);
    step();
    check("final cnt", instr_cnt, cnt_exp());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
